// File: rtl/sampler_trigger_ctrl.sv
// Trigger/arm sequencer for the capture sampler. It watches the sample stream for a masked
// level or edge match, applies an optional post-trigger delay, then releases the sampler write reset.
module sampler_trigger_ctrl #(
    parameter int width     = 32,
    parameter int delayBits = 16,
    parameter int countBits = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     sample_in,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [width-1:0]     cfg_mask,
    input  logic [width-1:0]     cfg_value,
    input  logic                 cfg_edge,
    input  logic [delayBits-1:0] cfg_delay,
    input  logic                 smp_done,
    output logic                 smp_reset_n,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [width-1:0]     trig_sample,
    output logic [countBits-1:0] trig_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_smp_reset_n;
    logic                   r_busy;
    logic                   r_done_pulse;
    logic [width-1:0]       r_trig_sample;
    logic [countBits-1:0]   r_trig_count;

    logic [width-1:0]       r_mask;
    logic [width-1:0]       r_value;
    logic                   r_edge;
    logic [delayBits-1:0]   r_delay;
    logic [delayBits-1:0]   r_delay_cnt;
    logic                   r_prev_match;

    logic                   w_match;
    logic                   w_fire;

    // A zero mask makes every sample match.
    assign w_match = (((sample_in ^ r_value) & r_mask) == '0);
    // A done flag still high from the previous capture must never start a new one.
    assign w_fire  = !smp_done && (r_edge ? (w_match && !r_prev_match) : w_match);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_smp_reset_n <= 1'b0;
            r_busy        <= 1'b0;
            r_done_pulse  <= 1'b0;
            r_trig_sample <= '0;
            r_trig_count  <= '0;
            r_mask        <= '0;
            r_value       <= '0;
            r_edge        <= 1'b0;
            r_delay       <= '0;
            r_delay_cnt   <= '0;
            r_prev_match  <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (abort) begin
                r_state       <= S_IDLE;
                r_smp_reset_n <= 1'b0;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            r_mask        <= cfg_mask;
                            r_value       <= cfg_value;
                            r_edge        <= cfg_edge;
                            r_delay       <= cfg_delay;
                            // Condition already true at arm time must not count as an edge.
                            r_prev_match  <= 1'b1;
                            r_state       <= S_ARMED;
                            r_smp_reset_n <= 1'b0;
                            r_busy        <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        r_prev_match <= w_match;
                        if (w_fire) begin
                            r_trig_sample <= sample_in;
                            if (r_delay == '0) begin
                                r_state       <= S_CAPTURE;
                                r_smp_reset_n <= 1'b1;
                            end else begin
                                r_state     <= S_DELAY;
                                r_delay_cnt <= r_delay;
                            end
                        end
                    end
                    S_DELAY: begin
                        r_delay_cnt <= r_delay_cnt - delayBits'(1);
                        if (r_delay_cnt == delayBits'(1)) begin
                            r_state       <= S_CAPTURE;
                            r_smp_reset_n <= 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        if (smp_done) begin
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_done_pulse <= 1'b1;
                            r_trig_count <= r_trig_count + countBits'(1);
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_smp_reset_n <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign smp_reset_n = r_smp_reset_n;
    assign state       = r_state;
    assign busy        = r_busy;
    assign done_pulse  = r_done_pulse;
    assign trig_sample = r_trig_sample;
    assign trig_count  = r_trig_count;

endmodule

// File: tb/tb_sampler_trigger_ctrl.sv
// Self-checking bench for sampler_trigger_ctrl: directed scenarios plus a randomized run
// against an event-level reference model that tracks the absolute capture-start cycle.
module tb_sampler_trigger_ctrl;

    localparam int W  = 32;
    localparam int DB = 16;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          reset, arm, abort, cfg_edge, smp_done;
    logic [W-1:0]  sample_in, cfg_mask, cfg_value;
    logic [DB-1:0] cfg_delay;
    logic          smp_reset_n, busy, done_pulse;
    logic [2:0]    state;
    logic [W-1:0]  trig_sample;
    logic [CB-1:0] trig_count;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int            m_state = 0;
    logic          m_srn = 1'b0, m_pulse = 1'b0, m_edge = 1'b0, m_prev = 1'b0;
    logic [W-1:0]  m_trig = '0, m_mask = '0, m_value = '0;
    int            m_delay = 0;
    logic [CB-1:0] m_count = '0;
    longint        m_cyc = 0, m_cap_at = 0;

    always #5 clk = ~clk;

    sampler_trigger_ctrl #(.width(W), .delayBits(DB), .countBits(CB)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .arm(arm), .abort(abort),
        .cfg_mask(cfg_mask), .cfg_value(cfg_value), .cfg_edge(cfg_edge), .cfg_delay(cfg_delay),
        .smp_done(smp_done), .smp_reset_n(smp_reset_n), .state(state), .busy(busy),
        .done_pulse(done_pulse), .trig_sample(trig_sample), .trig_count(trig_count)
    );

    // Advances the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic hit, fire;
        m_cyc++;
        m_pulse = 1'b0;
        if (reset) begin
            m_state = 0; m_srn = 1'b0; m_trig = '0; m_count = '0;
            return;
        end
        if (abort) begin
            m_state = 0; m_srn = 1'b0;
            return;
        end
        case (m_state)
            0, 4: if (arm) begin
                m_mask = cfg_mask; m_value = cfg_value; m_edge = cfg_edge; m_delay = int'(cfg_delay);
                m_prev = 1'b1; m_state = 1; m_srn = 1'b0;
            end
            1: begin
                hit  = (((sample_in ^ m_value) & m_mask) == 0);
                fire = !smp_done && (m_edge ? (hit && !m_prev) : hit);
                m_prev = hit;
                if (fire) begin
                    m_trig = sample_in;
                    if (m_delay == 0) begin m_state = 3; m_srn = 1'b1; end
                    else begin m_state = 2; m_cap_at = m_cyc + longint'(m_delay); end
                end
            end
            2: if (m_cyc == m_cap_at) begin m_state = 3; m_srn = 1'b1; end
            3: if (smp_done) begin m_state = 4; m_pulse = 1'b1; m_count++; end
            default: ;
        endcase
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        reset = 1'b0; arm = 1'b0; abort = 1'b0; cfg_edge = 1'b0; smp_done = 1'b0;
        sample_in = '0; cfg_mask = '0; cfg_value = '0; cfg_delay = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        init_inputs();
        reset = 1'b1; arm = 1'b1; sample_in = 32'hFFFF_FFFF;
        tick(); tick();
        reset = 1'b0; arm = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL reset_srn: got %b want 0", smp_reset_n); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", done_pulse); else n_pass++;
        n_total++; if (trig_sample !== '0) $display("FAIL reset_trig_sample: got %h want 0", trig_sample); else n_pass++;
        n_total++; if (trig_count !== '0) $display("FAIL reset_count: got %0d want 0", trig_count); else n_pass++;
    endtask

    task automatic test_level_trigger();
        logic early;
        init_inputs(); do_reset();
        cfg_mask = 32'hFF; cfg_value = 32'h5A; cfg_delay = '0;
        arm = 1'b1; tick(); arm = 1'b0;
        n_total++; if (state !== 3'd1) $display("FAIL level_armed: got %0d want 1", state); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL level_armed_busy: got %b want 1", busy); else n_pass++;
        early = 1'b0;
        for (int i = 0; i <= 'h5A; i++) begin
            sample_in = W'(i);
            tick();
            if (i < 'h5A && state !== 3'd1) early = 1'b1;
        end
        n_total++; if (early !== 1'b0) $display("FAIL level_early_trigger: got %b want 0", early); else n_pass++;
        n_total++; if (state !== 3'd3) $display("FAIL level_capture: got %0d want 3", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b1) $display("FAIL level_srn: got %b want 1", smp_reset_n); else n_pass++;
        n_total++; if (trig_sample !== 32'h5A) $display("FAIL level_trig_sample: got %h want 5a", trig_sample); else n_pass++;
        sample_in = 32'h1234_5678;
        for (int i = 0; i < 1023; i++) tick();
        smp_done = 1'b1; tick();
        n_total++; if (done_pulse !== 1'b1) $display("FAIL level_pulse: got %b want 1", done_pulse); else n_pass++;
        n_total++; if (state !== 3'd4) $display("FAIL level_done: got %0d want 4", state); else n_pass++;
        n_total++; if (trig_count !== 8'd1) $display("FAIL level_count: got %0d want 1", trig_count); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL level_done_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b1) $display("FAIL level_done_srn: got %b want 1", smp_reset_n); else n_pass++;
        tick();
        n_total++; if (done_pulse !== 1'b0) $display("FAIL level_pulse_once: got %b want 0", done_pulse); else n_pass++;
        n_total++; if (trig_count !== 8'd1) $display("FAIL level_count_hold: got %0d want 1", trig_count); else n_pass++;
        smp_done = 1'b0;
    endtask

    task automatic test_edge_trigger();
        logic fired;
        init_inputs(); do_reset();
        cfg_mask = 32'h1; cfg_value = 32'h1; cfg_edge = 1'b1;
        sample_in = 32'h1; tick(); tick();
        arm = 1'b1; tick(); arm = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_in = {$urandom_range(0, 'hFFFF), 16'h0001};
            tick();
            if (state !== 3'd1) fired = 1'b1;
        end
        n_total++; if (fired !== 1'b0) $display("FAIL edge_held_high: got %b want 0", fired); else n_pass++;
        sample_in = 32'h2; tick();
        n_total++; if (state !== 3'd1) $display("FAIL edge_low: got %0d want 1", state); else n_pass++;
        sample_in = 32'h33; tick();
        n_total++; if (state !== 3'd3) $display("FAIL edge_rise: got %0d want 3", state); else n_pass++;
        n_total++; if (trig_sample !== 32'h33) $display("FAIL edge_trig_sample: got %h want 33", trig_sample); else n_pass++;
    endtask

    task automatic test_delay();
        logic early;
        init_inputs(); do_reset();
        cfg_mask = 32'hFF; cfg_value = 32'h11; cfg_delay = 16'd5;
        arm = 1'b1; tick(); arm = 1'b0;
        sample_in = 32'h11; tick();
        n_total++; if (state !== 3'd2) $display("FAIL delay_state: got %0d want 2", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL delay_srn: got %b want 0", smp_reset_n); else n_pass++;
        sample_in = '0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (state !== 3'd2 || smp_reset_n !== 1'b0) early = 1'b1;
        end
        n_total++; if (early !== 1'b0) $display("FAIL delay_early_capture: got %b want 0", early); else n_pass++;
        tick();
        n_total++; if (state !== 3'd3) $display("FAIL delay_capture: got %0d want 3", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b1) $display("FAIL delay_capture_srn: got %b want 1", smp_reset_n); else n_pass++;
        // Largest delay value the counter can hold
        do_reset();
        cfg_mask = '0; cfg_delay = 16'hFFFF;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        for (int i = 0; i < 65534; i++) tick();
        n_total++; if (state !== 3'd2) $display("FAIL delay_max_before: got %0d want 2", state); else n_pass++;
        tick();
        n_total++; if (state !== 3'd3) $display("FAIL delay_max_capture: got %0d want 3", state); else n_pass++;
    endtask

    task automatic test_rearm();
        init_inputs(); do_reset();
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        smp_done = 1'b1; tick();
        n_total++; if (state !== 3'd4) $display("FAIL rearm_done: got %0d want 4", state); else n_pass++;
        arm = 1'b1; tick(); arm = 1'b0;
        n_total++; if (state !== 3'd1) $display("FAIL rearm_armed: got %0d want 1", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL rearm_srn_fall: got %b want 0", smp_reset_n); else n_pass++;
        tick();
        n_total++; if (state !== 3'd1) $display("FAIL rearm_stale1: got %0d want 1", state); else n_pass++;
        tick();
        n_total++; if (state !== 3'd1) $display("FAIL rearm_stale2: got %0d want 1", state); else n_pass++;
        smp_done = 1'b0; tick();
        n_total++; if (state !== 3'd3) $display("FAIL rearm_trigger: got %0d want 3", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b1) $display("FAIL rearm_trigger_srn: got %b want 1", smp_reset_n); else n_pass++;
    endtask

    task automatic test_abort();
        init_inputs(); do_reset();
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        smp_done = 1'b1; tick(); smp_done = 1'b0;
        cfg_delay = 16'd6;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        n_total++; if (state !== 3'd2) $display("FAIL abort_in_delay_pre: got %0d want 2", state); else n_pass++;
        tick(); tick(); tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL abort_delay_state: got %0d want 0", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL abort_delay_srn: got %b want 0", smp_reset_n); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_delay_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (trig_count !== 8'd1) $display("FAIL abort_delay_count: got %0d want 1", trig_count); else n_pass++;
        cfg_delay = '0;
        arm = 1'b1; tick(); arm = 1'b0;
        tick(); tick(); tick();
        n_total++; if (state !== 3'd3) $display("FAIL abort_in_capture_pre: got %0d want 3", state); else n_pass++;
        abort = 1'b1; smp_done = 1'b1; tick(); abort = 1'b0; smp_done = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL abort_capture_state: got %0d want 0", state); else n_pass++;
        n_total++; if (done_pulse !== 1'b0) $display("FAIL abort_capture_pulse: got %b want 0", done_pulse); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL abort_capture_srn: got %b want 0", smp_reset_n); else n_pass++;
        n_total++; if (trig_count !== 8'd1) $display("FAIL abort_capture_count: got %0d want 1", trig_count); else n_pass++;
        abort = 1'b1; arm = 1'b1; tick(); abort = 1'b0; arm = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL abort_arm_same_cycle: got %0d want 0", state); else n_pass++;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        smp_done = 1'b1; tick(); smp_done = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL abort_done_state: got %0d want 0", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL abort_done_srn: got %b want 0", smp_reset_n); else n_pass++;
        n_total++; if (trig_count !== 8'd2) $display("FAIL abort_done_count: got %0d want 2", trig_count); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        init_inputs(); do_reset();
        for (int i = 1; i <= 256; i++) begin
            arm = 1'b1; tick(); arm = 1'b0;
            tick();
            smp_done = 1'b1; tick(); smp_done = 1'b0;
            if (i == 255) begin
                n_total++; if (trig_count !== 8'd255) $display("FAIL wrap_255: got %0d want 255", trig_count); else n_pass++;
            end
        end
        n_total++; if (trig_count !== 8'd0) $display("FAIL wrap_0: got %0d want 0", trig_count); else n_pass++;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        smp_done = 1'b1; tick(); smp_done = 1'b0;
        sample_in = 32'hDEAD_BEEF;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        n_total++; if (trig_sample !== 32'hDEAD_BEEF) $display("FAIL rst_cap_pre_sample: got %h want deadbeef", trig_sample); else n_pass++;
        n_total++; if (trig_count !== 8'd1) $display("FAIL rst_cap_pre_count: got %0d want 1", trig_count); else n_pass++;
        reset = 1'b1; tick(); reset = 1'b0;
        n_total++; if (state !== 3'd0) $display("FAIL rst_cap_state: got %0d want 0", state); else n_pass++;
        n_total++; if (smp_reset_n !== 1'b0) $display("FAIL rst_cap_srn: got %b want 0", smp_reset_n); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_cap_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (trig_sample !== '0) $display("FAIL rst_cap_sample: got %h want 0", trig_sample); else n_pass++;
        n_total++; if (trig_count !== 8'd0) $display("FAIL rst_cap_count: got %0d want 0", trig_count); else n_pass++;
    endtask

    task automatic test_random();
        int hi_cnt, stale, len;
        logic exp_busy;
        init_inputs(); do_reset();
        hi_cnt = 0; stale = 0; len = 1;
        for (int c = 0; c < 3000; c++) begin
            // Sampler stand-in: done rises after a random capture length, may linger after reset_n falls
            if (m_srn) begin
                if (hi_cnt == 0) len = $urandom_range(1, 12);
                hi_cnt++;
                smp_done = (hi_cnt > len);
            end else begin
                if (hi_cnt != 0) begin stale = $urandom_range(0, 2); hi_cnt = 0; end
                if (stale > 0) stale--; else smp_done = 1'b0;
            end
            reset     = ($urandom_range(0, 255) == 0);
            abort     = ($urandom_range(0, 63) == 0);
            arm       = ($urandom_range(0, 7) == 0);
            sample_in = $urandom;
            cfg_mask  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 15));
            cfg_value = $urandom;
            cfg_edge  = 1'($urandom_range(0, 1));
            cfg_delay = DB'($urandom_range(0, 6));
            tick();
            exp_busy = (m_state >= 1 && m_state <= 3);
            n_total++; if (state !== 3'(m_state)) $display("FAIL rnd_state c=%0d: got %0d want %0d", c, state, m_state); else n_pass++;
            n_total++; if (smp_reset_n !== m_srn) $display("FAIL rnd_srn c=%0d: got %b want %b", c, smp_reset_n, m_srn); else n_pass++;
            n_total++; if (busy !== exp_busy) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, exp_busy); else n_pass++;
            n_total++; if (done_pulse !== m_pulse) $display("FAIL rnd_pulse c=%0d: got %b want %b", c, done_pulse, m_pulse); else n_pass++;
            n_total++; if (trig_sample !== m_trig) $display("FAIL rnd_trig_sample c=%0d: got %h want %h", c, trig_sample, m_trig); else n_pass++;
            n_total++; if (trig_count !== m_count) $display("FAIL rnd_count c=%0d: got %0d want %0d", c, trig_count, m_count); else n_pass++;
        end
        init_inputs();
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_level_trigger();
        test_edge_trigger();
        test_delay();
        test_rearm();
        test_abort();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
